// File: rtl/vec_cpu_pkg.sv
// Shared types and default sizes for the vector CPU datapath.
package vec_cpu_pkg;

  localparam int unsigned LANES_DEF  = 8;
  localparam int unsigned ELEM_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 16;

  // Bit 1 selects load, bit 0 selects scalar.
  typedef enum logic [1:0] {
    MOP_GV = 2'b00,  // store vector
    MOP_GE = 2'b01,  // store scalar
    MOP_CV = 2'b10,  // load vector
    MOP_CE = 2'b11   // load scalar
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } vmem_state_e;

  function automatic logic op_is_load(input mem_op_e op);
    return op[1];
  endfunction

  function automatic logic op_is_vec(input mem_op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/vmem_addr_gen.sv
// Lane counter, base/stride address accumulator and last-lane flag.
module vmem_addr_gen #(
  parameter int unsigned LANES  = 8,
  parameter int unsigned ADDR_W = 16,
  localparam int unsigned IdxW  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_vec,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] stride,
  output logic [ADDR_W-1:0] addr,
  output logic [IdxW-1:0]   idx,
  output logic              last
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [IdxW-1:0]   idx_q;
  logic [IdxW-1:0]   last_idx_q;

  // Load on start, then advance one lane per RUN cycle; address wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      stride_q   <= '0;
      idx_q      <= '0;
      last_idx_q <= '0;
    end else if (start) begin
      addr_q     <= base;
      stride_q   <= stride;
      idx_q      <= '0;
      last_idx_q <= is_vec ? IdxW'(LANES - 1) : '0;
    end else if (step) begin
      addr_q <= addr_q + stride_q;
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign addr = addr_q;
  assign idx  = idx_q;
  assign last = (idx_q == last_idx_q);

endmodule

// File: rtl/vec_mem_unit.sv
// Vector/scalar load-store engine: sequences single-port data-memory accesses lane by lane.
// Optional feature: define VEC_MEM_STRIDE_EN to add a per-operation address stride input.
module vec_mem_unit
  import vec_cpu_pkg::*;
#(
  parameter int unsigned LANES  = LANES_DEF,
  parameter int unsigned ELEM_W = ELEM_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cl_mem_st,
  input  logic [1:0]              cl_mem_op,
  input  logic [ADDR_W-1:0]       base_addr,
`ifdef VEC_MEM_STRIDE_EN
  input  logic [ADDR_W-1:0]       stride,
`endif
  input  logic [LANES*ELEM_W-1:0] vec_wdata,
  input  logic [ELEM_W-1:0]       esc_wdata,
  output logic                    mem_rdy,
  output logic [LANES*ELEM_W-1:0] vec_rdata,
  output logic [ELEM_W-1:0]       esc_rdata,
  output logic [ADDR_W-1:0]       dmem_addr,
  output logic                    dmem_we,
  output logic [ELEM_W-1:0]       dmem_wdata,
  input  logic [ELEM_W-1:0]       dmem_rdata
);

  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  vmem_state_e state_q, state_d;
  mem_op_e     op_q;
  logic [LANES*ELEM_W-1:0] vec_wdata_q;
  logic [ELEM_W-1:0]       esc_wdata_q;
  logic [LANES*ELEM_W-1:0] ld_buf_q;
  logic [LANES*ELEM_W-1:0] vec_rdata_q;
  logic [ELEM_W-1:0]       esc_rdata_q;

  logic              start;
  logic              is_load;
  logic              is_vec;
  logic [ADDR_W-1:0] stride_eff;
  logic [ADDR_W-1:0] lane_addr;
  logic [IdxW-1:0]   idx;
  logic [IdxW-1:0]   cap_idx;
  logic              last;
  logic [ELEM_W-1:0] lane_wdata;
  logic [LANES*ELEM_W-1:0] vec_merge;

`ifdef VEC_MEM_STRIDE_EN
  assign stride_eff = stride;
`else
  assign stride_eff = ADDR_W'(1);
`endif

  assign start   = (state_q == IDLE) && cl_mem_st;
  assign is_load = op_is_load(op_q);
  assign is_vec  = op_is_vec(op_q);
  // Read data lags the address by one cycle, so it belongs to the previous lane.
  assign cap_idx = idx - 1'b1;

  vmem_addr_gen #(
    .LANES  (LANES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .is_vec (op_is_vec(mem_op_e'(cl_mem_op))),
    .step   (state_q == RUN),
    .base   (base_addr),
    .stride (stride_eff),
    .addr   (lane_addr),
    .idx    (idx),
    .last   (last)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Select the store element for the current lane.
  always_comb begin
    lane_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      if (idx == IdxW'(i)) lane_wdata = vec_wdata_q[i*ELEM_W +: ELEM_W];
    end
  end

  // Next state and memory-port drive; port is quiet outside RUN.
  always_comb begin
    state_d    = state_q;
    mem_rdy    = 1'b0;
    dmem_addr  = '0;
    dmem_we    = 1'b0;
    dmem_wdata = '0;
    unique case (state_q)
      IDLE: if (cl_mem_st) state_d = RUN;
      RUN: begin
        dmem_addr = lane_addr;
        if (!is_load) begin
          dmem_we    = 1'b1;
          dmem_wdata = is_vec ? lane_wdata : esc_wdata_q;
        end
        if (last) state_d = is_load ? DRAIN : DONE;
      end
      DRAIN: state_d = DONE;
      DONE: begin
        mem_rdy = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request so inputs may change while the operation runs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= MOP_GV;
      vec_wdata_q <= '0;
      esc_wdata_q <= '0;
    end else if (start) begin
      op_q        <= mem_op_e'(cl_mem_op);
      vec_wdata_q <= vec_wdata;
      esc_wdata_q <= esc_wdata;
    end
  end

  // Final vector result: buffered lanes plus the word arriving in DRAIN.
  always_comb begin
    vec_merge = ld_buf_q;
    vec_merge[(LANES-1)*ELEM_W +: ELEM_W] = dmem_rdata;
  end

  // Gather load lanes into a shadow buffer; publish results only on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_buf_q    <= '0;
      vec_rdata_q <= '0;
      esc_rdata_q <= '0;
    end else begin
      if (state_q == RUN && is_load && idx != '0) begin
        for (int i = 0; i < LANES; i++) begin
          if (cap_idx == IdxW'(i)) ld_buf_q[i*ELEM_W +: ELEM_W] <= dmem_rdata;
        end
      end
      if (state_q == DRAIN) begin
        if (is_vec) vec_rdata_q <= vec_merge;
        else        esc_rdata_q <= dmem_rdata;
      end
    end
  end

  assign vec_rdata = vec_rdata_q;
  assign esc_rdata = esc_rdata_q;

endmodule

// File: tb/tb_vec_mem_unit.sv
// Directed self-checking bench for vec_mem_unit with a single-port memory model.
// Stride tests are compiled in when VEC_MEM_STRIDE_EN is defined.
module tb_vec_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        cl_mem_st;
  logic [1:0]  cl_mem_op;
  logic [15:0] base_addr;
`ifdef VEC_MEM_STRIDE_EN
  logic [15:0] stride;
`endif
  logic [63:0] vec_wdata;
  logic [7:0]  esc_wdata;
  logic        mem_rdy;
  logic [63:0] vec_rdata;
  logic [7:0]  esc_rdata;
  logic [15:0] dmem_addr;
  logic        dmem_we;
  logic [7:0]  dmem_wdata;
  logic [7:0]  dmem_rdata;

  logic [7:0]  mem [0:65535];

  int vectors = 0;
  int miscompares = 0;

  vec_mem_unit dut (
    .clk        (clk),
    .rst        (rst),
    .cl_mem_st  (cl_mem_st),
    .cl_mem_op  (cl_mem_op),
    .base_addr  (base_addr),
`ifdef VEC_MEM_STRIDE_EN
    .stride     (stride),
`endif
    .vec_wdata  (vec_wdata),
    .esc_wdata  (esc_wdata),
    .mem_rdy    (mem_rdy),
    .vec_rdata  (vec_rdata),
    .esc_rdata  (esc_rdata),
    .dmem_addr  (dmem_addr),
    .dmem_we    (dmem_we),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port memory: read data valid the cycle after the address.
  always @(posedge clk) begin
    dmem_rdata <= mem[dmem_addr];
    if (dmem_we) mem[dmem_addr] = dmem_wdata;
  end

  task automatic kick(input logic [1:0] op, input logic [15:0] base, input logic [63:0] vw,
                      input logic [7:0] ew);
    @(negedge clk);
    cl_mem_op = op;
    base_addr = base;
    vec_wdata = vw;
    esc_wdata = ew;
    cl_mem_st = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cl_mem_st = 1'b0;
    cl_mem_op = 2'b00;
    base_addr = '0;
    vec_wdata = '0;
    esc_wdata = '0;
`ifdef VEC_MEM_STRIDE_EN
    stride = 16'd1;
`endif
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_rdy, dmem_we, dmem_addr, dmem_wdata} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_port: got rdy=%0b we=%0b addr=%h wdata=%h, want all 0",
               mem_rdy, dmem_we, dmem_addr, dmem_wdata);
    end
    vectors++;
    if ({vec_rdata, esc_rdata} !== 72'd0) begin
      miscompares++;
      $display("FAIL reset_rdata: got vec=%h esc=%h, want 0", vec_rdata, esc_rdata);
    end
    rst = 1'b0;
  endtask

  // Checks port activity of a vector store: k=1..8 writes, mem_rdy at k=9.
  task automatic check_store_vec(input string name, input logic [15:0] base,
                                 input logic [63:0] vw, input int hold);
    logic [25:0] exp;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k > hold) cl_mem_st = 1'b0;
      if (k <= 8) exp = {1'b0, 1'b1, 16'(base + 16'(k - 1)), vw[(k-1)*8 +: 8]};
      else        exp = {k == 9, 1'b0, 16'h0, 8'h0};
      vectors++;
      if ({mem_rdy, dmem_we, dmem_addr, dmem_wdata} !== exp) begin
        miscompares++;
        $display("FAIL %s k=%0d: got rdy/we/addr/wd=%b/%b/%h/%h want %b/%b/%h/%h", name, k,
                 mem_rdy, dmem_we, dmem_addr, dmem_wdata, exp[25], exp[24], exp[23:8], exp[7:0]);
      end
    end
  endtask

  task automatic test_store_vec;
    logic [63:0] vw;
    for (int i = 0; i < 8; i++) vw[i*8 +: 8] = 8'(17 * (i + 1));
    kick(2'b00, 16'h0010, vw, 8'h00);
    check_store_vec("store_vec", 16'h0010, vw, 0);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (mem[16'h0010 + 16'(i)] !== 8'(17 * (i + 1))) begin
        miscompares++;
        $display("FAIL store_vec_mem[%0d]: got %h want %h", i, mem[16'h0010 + 16'(i)],
                 8'(17 * (i + 1)));
      end
    end
  endtask

  // Vector load: address pattern in RUN, result valid with mem_rdy at k=10.
  task automatic check_load_vec(input string name, input logic [15:0] base,
                                input logic [15:0] step, input logic [63:0] exp_vec,
                                input logic [63:0] old_vec, input logic [7:0] exp_esc);
    logic [17:0] exp;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      cl_mem_st = 1'b0;
      exp = {k == 10, 1'b0, (k <= 8) ? 16'(base + 16'(k - 1) * step) : 16'h0};
      vectors++;
      if ({mem_rdy, dmem_we, dmem_addr} !== exp) begin
        miscompares++;
        $display("FAIL %s k=%0d: got rdy/we/addr=%b/%b/%h want %b/%b/%h", name, k,
                 mem_rdy, dmem_we, dmem_addr, exp[17], exp[16], exp[15:0]);
      end
      if (k == 9 || k == 10) begin
        vectors++;
        if (vec_rdata !== ((k == 9) ? old_vec : exp_vec) || esc_rdata !== exp_esc) begin
          miscompares++;
          $display("FAIL %s_data k=%0d: got vec=%h esc=%h want vec=%h esc=%h", name, k,
                   vec_rdata, esc_rdata, (k == 9) ? old_vec : exp_vec, exp_esc);
        end
      end
    end
  endtask

  task automatic test_load_vec;
    logic [63:0] ev;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0020 + 16'(i)] = 8'hA0 + 8'(i);
      ev[i*8 +: 8] = 8'hA0 + 8'(i);
    end
    kick(2'b10, 16'h0020, '0, 8'h00);
    check_load_vec("load_vec", 16'h0020, 16'd1, ev, 64'd0, 8'h00);
  endtask

  task automatic test_load_esc;
    logic [17:0] exp;
    mem[16'hFFFF] = 8'h5C;
    kick(2'b11, 16'hFFFF, '0, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cl_mem_st = 1'b0;
      exp = {k == 3, 1'b0, (k == 1) ? 16'hFFFF : 16'h0};
      vectors++;
      if ({mem_rdy, dmem_we, dmem_addr} !== exp) begin
        miscompares++;
        $display("FAIL load_esc k=%0d: got rdy/we/addr=%b/%b/%h want %b/%b/%h", k,
                 mem_rdy, dmem_we, dmem_addr, exp[17], exp[16], exp[15:0]);
      end
    end
    vectors++;
    if (esc_rdata !== 8'h5C || vec_rdata !== 64'hA7A6A5A4A3A2A1A0) begin
      miscompares++;
      $display("FAIL load_esc_data: got esc=%h vec=%h want esc=5c vec=a7a6a5a4a3a2a1a0",
               esc_rdata, vec_rdata);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] ev;
    for (int i = 0; i < 8; i++) begin
      mem[16'(16'hFFFE + 16'(i))] = 8'h30 + 8'(i);
      ev[i*8 +: 8] = 8'h30 + 8'(i);
    end
    kick(2'b10, 16'hFFFE, '0, 8'h00);
    check_load_vec("wrap", 16'hFFFE, 16'd1, ev, 64'hA7A6A5A4A3A2A1A0, 8'h5C);
  endtask

  task automatic test_held_start;
    logic [63:0] vw;
    for (int i = 0; i < 8; i++) vw[i*8 +: 8] = 8'h50 + 8'(i);
    kick(2'b00, 16'h0090, vw, 8'h00);
    check_store_vec("held_start", 16'h0090, vw, 6);
  endtask

  // Start held through DONE is ignored there and accepted on the next IDLE cycle.
  task automatic test_back_to_back;
    kick(2'b01, 16'h0080, '0, 8'h3C);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k >= 4) cl_mem_st = 1'b0;
      vectors++;
      if (mem_rdy !== (k == 2 || k == 5)) begin
        miscompares++;
        $display("FAIL back_to_back k=%0d: got rdy=%b want %b", k, mem_rdy, (k == 2 || k == 5));
      end
    end
    vectors++;
    if (mem[16'h0080] !== 8'h3C) begin
      miscompares++;
      $display("FAIL back_to_back_mem: got %h want 3c", mem[16'h0080]);
    end
  endtask

  task automatic test_reset_mid;
    kick(2'b00, 16'h0100, 64'h0807060504030201, 8'h00);
    repeat (3) @(negedge clk);
    cl_mem_st = 1'b0;
    vectors++;
    if ({dmem_we, dmem_addr, dmem_wdata} !== {1'b1, 16'h0102, 8'h03}) begin
      miscompares++;
      $display("FAIL reset_mid_pre: got we/addr/wd=%b/%h/%h want 1/0102/03",
               dmem_we, dmem_addr, dmem_wdata);
    end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({mem_rdy, dmem_we, dmem_addr, dmem_wdata, vec_rdata, esc_rdata} !== 98'd0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got rdy/we/addr/wd=%b/%b/%h/%h vec=%h esc=%h want 0",
               mem_rdy, dmem_we, dmem_addr, dmem_wdata, vec_rdata, esc_rdata);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      vectors++;
      if ({mem_rdy, dmem_we} !== 2'b00) begin
        miscompares++;
        $display("FAIL reset_mid_idle k=%0d: got rdy/we=%b/%b want 0/0", k, mem_rdy, dmem_we);
      end
    end
    kick(2'b01, 16'h0200, '0, 8'hE7);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      cl_mem_st = 1'b0;
      vectors++;
      if (mem_rdy !== (k == 2)) begin
        miscompares++;
        $display("FAIL reset_mid_after k=%0d: got rdy=%b want %b", k, mem_rdy, (k == 2));
      end
    end
    vectors++;
    if (mem[16'h0200] !== 8'hE7) begin
      miscompares++;
      $display("FAIL reset_mid_mem: got %h want e7", mem[16'h0200]);
    end
  endtask

`ifdef VEC_MEM_STRIDE_EN
  task automatic test_stride;
    logic [63:0] ev1, ev2;
    for (int i = 0; i < 8; i++) begin
      mem[16'h0040 + 16'(3 * i)] = 8'hC0 + 8'(i);
      ev1[i*8 +: 8] = 8'hC0 + 8'(i);
    end
    stride = 16'd3;
    kick(2'b10, 16'h0040, '0, 8'h00);
    check_load_vec("stride3", 16'h0040, 16'd3, ev1, 64'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      mem[16'h0050 - 16'(i)] = 8'hD0 + 8'(i);
      ev2[i*8 +: 8] = 8'hD0 + 8'(i);
    end
    stride = 16'hFFFF;
    kick(2'b10, 16'h0050, '0, 8'h00);
    check_load_vec("stride_dec", 16'h0050, 16'hFFFF, ev2, ev1, 8'h00);
    stride = 16'd1;
  endtask
`endif

  initial begin
    test_reset();
    test_store_vec();
    test_load_vec();
    test_load_esc();
    test_wrap();
    test_held_start();
    test_back_to_back();
    test_reset_mid();
`ifdef VEC_MEM_STRIDE_EN
    test_stride();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
